// File: rtl/raster_to_block_pkg.sv
// tiler_pkg: shared block geometry, read-side FSM states and index-width helper
package tiler_pkg;
    localparam int BLK = 8;
    localparam int BLK_PIX = 64;
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    // Index width for a count of n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/raster_to_block_if.sv
// raster_to_block_if: pixel-stream input and block-window output handshakes
interface raster_to_block_if #(parameter int N = 10, parameter int WIDTH = 128, parameter int HEIGHT = 128);
    import tiler_pkg::*;
    localparam int RW = idx_w(HEIGHT / BLK);
    localparam int CW = idx_w(WIDTH / BLK);
    logic in_valid;
    logic in_ready;
    logic [N-1:0] in_pixel;
    logic win_valid;
    logic win_ready;
    logic [N*BLK_PIX-1:0] win_data;
    logic [RW-1:0] blk_row;
    logic [CW-1:0] blk_col;
    logic last_block;
    modport master (output in_valid, in_pixel, win_ready, input in_ready, win_valid, win_data, blk_row, blk_col, last_block);
    modport slave (input in_valid, in_pixel, win_ready, output in_ready, win_valid, win_data, blk_row, blk_col, last_block);
endinterface

// File: rtl/raster_to_block_strip_bank.sv
// strip_bank: one 8-row strip buffer with a pixel write port and an 8x8 window read
module strip_bank import tiler_pkg::*; #(parameter int N = 10, parameter int WIDTH = 128) (
    input  logic clk,
    input  logic we,
    input  logic [2:0] row,
    input  logic [idx_w(WIDTH/BLK)+2:0] col,
    input  logic [N-1:0] data,
    input  logic [idx_w(WIDTH/BLK)-1:0] sel,
    output logic [N*BLK_PIX-1:0] window
);
    logic [N-1:0] mem [BLK][WIDTH];
    // Store each accepted pixel at its strip row and column.
    always_ff @(posedge clk) begin
        if (we) mem[row][col] <= data;
    end
    // Flatten the selected block column row-major into the window.
    always_comb begin
        window = '0;
        for (int r = 0; r < BLK; r++)
            for (int c = 0; c < BLK; c++)
                window[(r*BLK+c)*N +: N] = mem[r][{sel, 3'(c)}];
    end
endmodule

// File: rtl/raster_to_block.sv
// raster_to_block: raster pixel stream to 8x8 block windows via ping-pong strip banks
module raster_to_block import tiler_pkg::*; #(parameter int N = 10, parameter int WIDTH = 128, parameter int HEIGHT = 128) (
    input logic clk,
    input logic rst,
    raster_to_block_if.slave bus
);
    localparam int CB = idx_w(WIDTH / BLK);
    localparam int RB = idx_w(HEIGHT / BLK);
    localparam logic [CB+2:0] COL_MAX = (CB+3)'(WIDTH - 1);
    localparam logic [RB+2:0] ROW_MAX = (RB+3)'(HEIGHT - 1);
    localparam logic [CB-1:0] BCOL_MAX = CB'(WIDTH / BLK - 1);
    localparam logic [RB-1:0] STRIP_MAX = RB'(HEIGHT / BLK - 1);
    logic [CB+2:0] col;
    logic [RB+2:0] row;
    logic wr_bank, rd_bank;
    logic [1:0] full;
    logic [CB-1:0] rd_col;
    logic [RB-1:0] rd_strip;
    state_t state;
    logic [N*BLK_PIX-1:0] win0, win1;
    logic accept, strip_done, release_bank;
    assign bus.in_ready = ~rst & ~full[wr_bank];
    assign accept = bus.in_valid & bus.in_ready;
    assign strip_done = accept & (row[2:0] == 3'd7) & (col == COL_MAX);
    assign release_bank = (state == SEND) & bus.win_ready & (rd_col == BCOL_MAX);
    strip_bank #(.N(N), .WIDTH(WIDTH)) bank0 (
        .clk(clk), .we(accept & ~wr_bank), .row(row[2:0]), .col(col),
        .data(bus.in_pixel), .sel(rd_col), .window(win0)
    );
    strip_bank #(.N(N), .WIDTH(WIDTH)) bank1 (
        .clk(clk), .we(accept & wr_bank), .row(row[2:0]), .col(col),
        .data(bus.in_pixel), .sel(rd_col), .window(win1)
    );
    // Track the raster position of the next pixel and flip banks at each strip end.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            col <= col == COL_MAX ? '0 : col + 1'b1;
            if (col == COL_MAX) row <= row == ROW_MAX ? '0 : row + 1'b1;
            if (strip_done) wr_bank <= ~wr_bank;
        end
    end
    // Writer fills and reader releases always hit different banks, so both apply.
    always_ff @(posedge clk) begin
        full <= rst ? 2'b00 : (full | ({1'b0, strip_done} << wr_bank)) & ~({1'b0, release_bank} << rd_bank);
    end
    // Walk the block columns of each full strip, one registered window at a time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rd_bank <= 1'b0;
            rd_col <= '0;
            rd_strip <= '0;
            bus.win_valid <= 1'b0;
            bus.win_data <= '0;
            bus.blk_row <= '0;
            bus.blk_col <= '0;
            bus.last_block <= 1'b0;
        end else begin
            case (state)
                IDLE: if (full[rd_bank]) state <= LOAD;
                LOAD: begin
                    bus.win_data <= rd_bank ? win1 : win0;
                    bus.blk_col <= rd_col;
                    bus.blk_row <= rd_strip;
                    bus.last_block <= (rd_col == BCOL_MAX) && (rd_strip == STRIP_MAX);
                    bus.win_valid <= 1'b1;
                    state <= SEND;
                end
                SEND: if (bus.win_ready) begin
                    bus.win_valid <= 1'b0;
                    if (rd_col != BCOL_MAX) begin
                        rd_col <= rd_col + 1'b1;
                        state <= LOAD;
                    end else begin
                        rd_col <= '0;
                        rd_bank <= ~rd_bank;
                        rd_strip <= rd_strip == STRIP_MAX ? '0 : rd_strip + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
